// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: condition codes, flag bit
// positions and the FSM state encoding.
package branch_resolver_pkg;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_GT = 3'b101;
  localparam logic [2:0] COND_LE = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  // Bit positions inside the latched {N,Z,V} flag vector.
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EVAL = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Always/never branches resolve without looking at the flags.
  function automatic logic cond_is_static(input logic [2:0] cond);
    return (cond == COND_AL) || (cond == COND_NV);
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Bundle of ALU-flag, branch-request and resolution signals for the resolver.
interface branch_resolver_if #(
  parameter int DATA_W = 16
);
  logic              alu_en;
  logic              alu_zero;
  logic              alu_negative;
  logic              alu_overflow;
  logic              flag_clear;

  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_cond;
  logic [DATA_W-1:0] br_pc;
  logic [DATA_W-1:0] br_offset;

  logic              res_valid;
  logic              res_ready;
  logic              res_taken;
  logic [DATA_W-1:0] res_target;

  logic [2:0]        flags_out;
  logic              flags_valid;

  modport master (
    output alu_en, alu_zero, alu_negative, alu_overflow, flag_clear,
    output br_valid, br_cond, br_pc, br_offset, res_ready,
    input  br_ready, res_valid, res_taken, res_target, flags_out, flags_valid
  );

  modport slave (
    input  alu_en, alu_zero, alu_negative, alu_overflow, flag_clear,
    input  br_valid, br_cond, br_pc, br_offset, res_ready,
    output br_ready, res_valid, res_taken, res_target, flags_out, flags_valid
  );
endinterface

// File: rtl/branch_resolver_cond_eval.sv
// Combinational condition-code evaluator over a latched {N,Z,V} flag vector.
module cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);
  logic z;
  logic lt;

  assign z  = flags[FLAG_Z];
  // Signed less-than: negative result unless the subtraction overflowed.
  assign lt = flags[FLAG_N] ^ flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_LT: taken = lt;
      COND_GE: taken = ~lt;
      COND_GT: taken = ~z & ~lt;
      COND_LE: taken = z | lt;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: latches ALU flags, accepts one branch at a time, waits for
// valid flags if needed, then presents taken/target until the consumer accepts.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input logic               clk,
  input logic               reset,
  branch_resolver_if.slave  bus
);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_e            state_q, state_d;
  logic [2:0]        flags_q, flags_d;
  logic              fvalid_q, fvalid_d;
  logic [2:0]        cond_q, cond_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] off_q, off_d;
  logic              taken_q, taken_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic              eval_taken;

  cond_eval u_cond_eval (
    .cond  (cond_q),
    .flags (flags_q),
    .taken (eval_taken)
  );

  // Flag register: a fresh ALU result always wins over a flush.
  always_comb begin
    flags_d  = flags_q;
    fvalid_d = fvalid_q;
    if (bus.alu_en) begin
      flags_d[FLAG_N] = bus.alu_negative;
      flags_d[FLAG_Z] = bus.alu_zero;
      flags_d[FLAG_V] = bus.alu_overflow;
      fvalid_d        = 1'b1;
    end else if (bus.flag_clear) begin
      fvalid_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cond_d   = cond_q;
    pc_d     = pc_q;
    off_d    = off_q;
    taken_d  = taken_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.br_valid) begin
          cond_d = bus.br_cond;
          pc_d   = bus.br_pc;
          off_d  = bus.br_offset;
          // Flags arriving on the accept edge are in the register by EVAL.
          if (cond_is_static(bus.br_cond) || fvalid_q || bus.alu_en)
            state_d = ST_EVAL;
          else
            state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.alu_en) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        taken_d  = eval_taken;
        target_d = pc_q + (eval_taken ? off_q : ONE);
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      flags_q  <= '0;
      fvalid_q <= 1'b0;
      cond_q   <= '0;
      pc_q     <= '0;
      off_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      fvalid_q <= fvalid_d;
      cond_q   <= cond_d;
      pc_q     <= pc_d;
      off_q    <= off_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign bus.br_ready    = (state_q == ST_IDLE);
  assign bus.res_valid   = (state_q == ST_HOLD);
  assign bus.res_taken   = taken_q;
  assign bus.res_target  = target_q;
  assign bus.flags_out   = flags_q;
  assign bus.flags_valid = fvalid_q;
endmodule
